// File: rtl/vga_fb_arbiter_pkg.sv
// Shared constants and clear-engine state encoding for the VGA framebuffer arbiter.
package vga_fb_arbiter_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int COLOUR_W = 3;
   localparam int X_W      = 10;
   localparam int Y_W      = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } clr_state_t;

   function automatic int fb_depth(input int shift);
      return (H_ACTIVE >> shift) * (V_ACTIVE >> shift);
   endfunction

endpackage

// File: rtl/vga_fb_arbiter_fb_addr_gen.sv
// Maps a visible-area pixel (x,y) to its downscaled framebuffer word address.
module vga_fb_arbiter_fb_addr_gen
   import vga_fb_arbiter_pkg::*;
#(
   parameter int SHIFT = 2,
   parameter int AW    = 15
)
(
   input  logic [X_W-1:0] x,
   input  logic [Y_W-1:0] y,
   output logic [AW-1:0]  addr
);

   localparam int FB_W = H_ACTIVE >> SHIFT;

   logic [AW-1:0] row;
   logic [AW-1:0] col;
   logic [AW-1:0] acc;

   // Row stride is a constant, so the multiply unrolls into one shifted add per set bit.
   always_comb begin
      row = AW'(y >> SHIFT);
      col = AW'(x >> SHIFT);
      acc = '0;
      for (int b = 0; b < AW; b++) begin
         if (FB_W[b]) acc = acc + (row << b);
      end
      addr = acc + col;
   end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: VGA scan-out always wins, clear engine beats the pixel writer.
module vga_fb_arbiter
   import vga_fb_arbiter_pkg::*;
#(
   parameter int SHIFT = 2,
   parameter int AW    = 15,
   parameter int CW    = COLOUR_W
)
(
   input  logic           in_clock,
   input  logic           in_reset,
   input  logic           in_strobe,
   input  logic [9:0]     in_x,
   input  logic [8:0]     in_y,
   input  logic           in_active,
   input  logic           in_wr_valid,
   input  logic [AW-1:0]  in_wr_addr,
   input  logic [CW-1:0]  in_wr_data,
   output logic           out_wr_ready,
   input  logic           in_clr_start,
   input  logic [CW-1:0]  in_clr_colour,
   output logic           out_clr_busy,
   output logic           out_clr_done,
   output logic [AW-1:0]  out_mem_addr,
   output logic           out_mem_we,
   output logic [CW-1:0]  out_mem_wdata,
   input  logic [CW-1:0]  in_mem_rdata,
   output logic           out_red,
   output logic           out_green,
   output logic           out_blue
);

   localparam int            FB_DEPTH  = fb_depth(SHIFT);
   localparam logic [AW-1:0] LAST_ADDR = AW'(FB_DEPTH - 1);
   localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(FB_DEPTH);

   logic          disp_p0;
   logic          blank_p0;
   logic [AW-1:0] disp_addr_p0;
   logic          wr_in_range_p0;
   logic          vld_p1;
   logic [2:0]    rgb_p2;

   clr_state_t    state;
   logic [AW-1:0] clr_cnt;
   logic [CW-1:0] clr_colour;

   vga_fb_arbiter_fb_addr_gen #(
      .SHIFT (SHIFT),
      .AW    (AW)
   ) u_addr_gen (
      .x    (in_x),
      .y    (in_y),
      .addr (disp_addr_p0)
   );

   // Stage p0: slot decode and RAM port mux
   assign disp_p0        = in_strobe & in_active;
   assign blank_p0       = in_strobe & ~in_active;
   assign wr_in_range_p0 = {1'b0, in_wr_addr} < DEPTH_EXT;
   assign out_wr_ready   = ~out_clr_busy & ~disp_p0;

   always_comb begin
      out_mem_addr  = '0;
      out_mem_we    = 1'b0;
      out_mem_wdata = '0;
      if (!in_reset) begin
         if (disp_p0) begin
            out_mem_addr = disp_addr_p0;
         end else if (state == ST_CLEAR) begin
            out_mem_addr  = clr_cnt;
            out_mem_we    = 1'b1;
            out_mem_wdata = clr_colour;
         end else if (in_wr_valid && out_wr_ready) begin
            out_mem_addr  = in_wr_addr;
            out_mem_we    = wr_in_range_p0;
            out_mem_wdata = in_wr_data;
         end
      end
   end

   // Clear engine: owns every free slot until the last word is written
   always_ff @(posedge in_clock) begin
      if (in_reset) begin
         state        <= ST_IDLE;
         clr_cnt      <= '0;
         clr_colour   <= '0;
         out_clr_busy <= 1'b0;
         out_clr_done <= 1'b0;
      end else begin
         out_clr_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_clr_start) begin
                  state        <= ST_CLEAR;
                  clr_colour   <= in_clr_colour;
                  clr_cnt      <= '0;
                  out_clr_busy <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (!disp_p0) begin
                  if (clr_cnt == LAST_ADDR) begin
                     state        <= ST_DONE;
                     out_clr_busy <= 1'b0;
                     out_clr_done <= 1'b1;
                  end else begin
                     clr_cnt <= clr_cnt + 1'b1;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Stage p1: RAM data returns; stage p2: colour lands on the pins
   always_ff @(posedge in_clock) begin
      if (in_reset) begin
         vld_p1 <= 1'b0;
         rgb_p2 <= '0;
      end else begin
         vld_p1 <= disp_p0;
         if (blank_p0)
            rgb_p2 <= '0;
         else if (vld_p1)
            rgb_p2 <= in_mem_rdata[2:0];
      end
   end

   assign out_red   = rgb_p2[2];
   assign out_green = rgb_p2[1];
   assign out_blue  = rgb_p2[0];

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized and directed checks of the framebuffer arbiter against a pixel-level reference model.
module tb_vga_fb_arbiter;

   localparam int AW    = 15;
   localparam int FB_W  = 160;
   localparam int FB_H  = 120;
   localparam int DEPTH = FB_W * FB_H;
   localparam int WORDS = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          strobe;
   logic [9:0]    x;
   logic [8:0]    y;
   logic          active;
   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic [2:0]    wr_data;
   logic          wr_ready;
   logic          clr_start;
   logic [2:0]    clr_colour;
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [2:0]    mem_wdata;
   logic [2:0]    mem_rdata;
   logic          red, green, blue;

   logic          pre_en;
   logic [AW-1:0] pre_addr;
   logic [2:0]    pre_data;

   logic [2:0]    ram    [0:WORDS-1];
   bit            ram_wr [0:WORDS-1];
   logic [2:0]    ref_fb [0:WORDS-1];

   int total = 0;
   int bad   = 0;

   always #10 clk = ~clk;

   vga_fb_arbiter dut (
      .in_clock      (clk),
      .in_reset      (rst),
      .in_strobe     (strobe),
      .in_x          (x),
      .in_y          (y),
      .in_active     (active),
      .in_wr_valid   (wr_valid),
      .in_wr_addr    (wr_addr),
      .in_wr_data    (wr_data),
      .out_wr_ready  (wr_ready),
      .in_clr_start  (clr_start),
      .in_clr_colour (clr_colour),
      .out_clr_busy  (busy),
      .out_clr_done  (done),
      .out_mem_addr  (mem_addr),
      .out_mem_we    (mem_we),
      .out_mem_wdata (mem_wdata),
      .in_mem_rdata  (mem_rdata),
      .out_red       (red),
      .out_green     (green),
      .out_blue      (blue)
   );

   function automatic logic [2:0] bg(input int a);
      return 3'(a ^ (a >> 3) ^ (a >> 7));
   endfunction

   function automatic int pix_addr(input int px, input int py);
      return (py / 4) * FB_W + px / 4;
   endfunction

   // Synchronous-read RAM; never-written words read back a fixed background pattern.
   always @(posedge clk) begin
      if (pre_en) begin
         ram[pre_addr]    <= pre_data;
         ram_wr[pre_addr] <= 1'b1;
      end else if (mem_we) begin
         ram[mem_addr]    <= mem_wdata;
         ram_wr[mem_addr] <= 1'b1;
      end
      mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : bg(int'(mem_addr));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; strobe = 1'b0; active = 1'b0; x = '0; y = '0;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr_start = 1'b0; clr_colour = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({red, green, blue} !== 3'b000) begin
            bad++; $display("FAIL reset_rgb cyc=%0d got=%b want=000", i, {red, green, blue});
         end
         total++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_clr cyc=%0d busy=%b done=%b want 0 0", i, busy, done);
         end
         total++;
         if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            bad++; $display("FAIL reset_mem cyc=%0d we=%b addr=%0d wdata=%b want 0 0 0", i, mem_we, mem_addr, mem_wdata);
         end
         total++;
         if (wr_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready cyc=%0d got=%b want=1", i, wr_ready);
         end
         tick();
      end
      rst = 1'b0;
   endtask

   task automatic test_random_traffic();
      logic [2:0] exp_rgb;
      int         due_q[$];
      logic [2:0] val_q[$];
      int         a;
      exp_rgb = 3'b000;
      for (int i = 0; i < 1500; i++) begin
         strobe   = (i % 2 == 0);
         active   = ($urandom_range(0, 3) != 0);
         x        = 10'($urandom_range(0, 639));
         y        = 9'($urandom_range(0, 479));
         wr_valid = 1'($urandom_range(0, 1));
         wr_addr  = AW'($urandom_range(0, DEPTH + 255));
         wr_data  = 3'($urandom);
         @(negedge clk);
         while (due_q.size() > 0 && due_q[0] == i) begin
            exp_rgb = val_q.pop_front();
            void'(due_q.pop_front());
         end
         total++;
         if ({red, green, blue} !== exp_rgb) begin
            bad++; $display("FAIL rand_rgb cyc=%0d got=%b want=%b", i, {red, green, blue}, exp_rgb);
         end
         total++;
         if (wr_ready !== !(strobe && active)) begin
            bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", i, wr_ready, !(strobe && active));
         end
         if (strobe && active) begin
            a = pix_addr(int'(x), int'(y));
            total++;
            if (mem_we !== 1'b0 || mem_addr !== AW'(a)) begin
               bad++; $display("FAIL rand_disp cyc=%0d we=%b addr=%0d want we=0 addr=%0d", i, mem_we, mem_addr, a);
            end
            due_q.push_back(i + 2);
            val_q.push_back(ref_fb[a]);
         end else begin
            if (strobe) begin
               due_q.push_back(i + 1);
               val_q.push_back(3'b000);
            end
            total++;
            if (wr_valid && int'(wr_addr) < DEPTH) begin
               if (mem_we !== 1'b1 || mem_addr !== wr_addr || mem_wdata !== wr_data) begin
                  bad++; $display("FAIL rand_write cyc=%0d we=%b addr=%0d wdata=%b want 1 %0d %b", i, mem_we, mem_addr, mem_wdata, wr_addr, wr_data);
               end
               ref_fb[wr_addr] = wr_data;
            end else if (wr_valid) begin
               if (mem_we !== 1'b0) begin
                  bad++; $display("FAIL rand_drop cyc=%0d we=%b want=0 addr=%0d", i, mem_we, wr_addr);
               end
            end else begin
               if (mem_we !== 1'b0 || mem_addr !== '0) begin
                  bad++; $display("FAIL rand_idle cyc=%0d we=%b addr=%0d want 0 0", i, mem_we, mem_addr);
               end
            end
         end
         tick();
      end
      wr_valid = 1'b0; strobe = 1'b0;
   endtask

   task automatic test_display_pixel();
      pre_en = 1'b1; pre_addr = AW'(161); pre_data = 3'b101; ref_fb[161] = 3'b101;
      strobe = 1'b0; wr_valid = 1'b0;
      tick();
      pre_en = 1'b0;
      strobe = 1'b1; active = 1'b1; x = 10'd4; y = 9'd4;
      @(negedge clk);
      total++;
      if (mem_addr !== AW'(161) || mem_we !== 1'b0) begin
         bad++; $display("FAIL disp_addr got addr=%0d we=%b want 161 0", mem_addr, mem_we);
      end
      tick(); strobe = 1'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      total++;
      if ({red, green, blue} !== ref_fb[161]) begin
         bad++; $display("FAIL disp_rgb got=%b want=%b", {red, green, blue}, ref_fb[161]);
      end
      tick(); strobe = 1'b1; active = 1'b0;
      @(negedge clk);
      tick(); strobe = 1'b0;
      @(negedge clk);
      total++;
      if ({red, green, blue} !== 3'b000) begin
         bad++; $display("FAIL disp_blank got=%b want=000", {red, green, blue});
      end
      tick();
   endtask

   task automatic test_writer_stall();
      strobe = 1'b1; active = 1'b1; x = '0; y = '0;
      wr_valid = 1'b1; wr_addr = AW'(100); wr_data = 3'b010;
      @(negedge clk);
      total++;
      if (wr_ready !== 1'b0 || mem_we !== 1'b0) begin
         bad++; $display("FAIL stall_hold ready=%b we=%b want 0 0", wr_ready, mem_we);
      end
      tick(); strobe = 1'b0;
      @(negedge clk);
      total++;
      if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(100) || mem_wdata !== 3'b010) begin
         bad++; $display("FAIL stall_accept ready=%b we=%b addr=%0d wdata=%b want 1 1 100 010", wr_ready, mem_we, mem_addr, mem_wdata);
      end
      ref_fb[100] = 3'b010;
      tick(); wr_valid = 1'b0; strobe = 1'b1; active = 1'b1; x = 10'd400; y = '0;
      @(negedge clk);
      tick(); strobe = 1'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      total++;
      if ({red, green, blue} !== ref_fb[100]) begin
         bad++; $display("FAIL stall_readback got=%b want=%b", {red, green, blue}, ref_fb[100]);
      end
      tick();
   endtask

   task automatic test_out_of_range();
      strobe = 1'b0; wr_valid = 1'b1; wr_addr = AW'(DEPTH); wr_data = 3'b111;
      @(negedge clk);
      total++;
      if (wr_ready !== 1'b1 || mem_we !== 1'b0) begin
         bad++; $display("FAIL oor_write ready=%b we=%b want 1 0", wr_ready, mem_we);
      end
      tick(); wr_valid = 1'b0; strobe = 1'b1; active = 1'b0;
      @(negedge clk);
      tick(); strobe = 1'b0;
      @(negedge clk);
      total++;
      if ({red, green, blue} !== 3'b000) begin
         bad++; $display("FAIL oor_blank got=%b want=000", {red, green, blue});
      end
      tick();
   endtask

   task automatic test_clear();
      logic [2:0] col;
      int  written, c, a;
      bit  exp_busy, exp_done, finished, disp;
      col = 3'b111; written = 0; c = 0; exp_busy = 1'b0; exp_done = 1'b0; finished = 1'b0;
      strobe = 1'b0; wr_valid = 1'b0; clr_start = 1'b1; clr_colour = col;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL clr_start_busy got=%b want=0", busy);
      end
      tick(); clr_start = 1'b0; exp_busy = 1'b1;
      while (!finished && c < 45000) begin
         strobe     = (c % 2 == 0);
         active     = 1'($urandom_range(0, 1));
         x          = 10'($urandom_range(0, 639));
         y          = 9'($urandom_range(0, 479));
         wr_valid   = exp_busy ? 1'($urandom_range(0, 1)) : 1'b0;
         wr_addr    = AW'($urandom_range(0, DEPTH - 1));
         wr_data    = 3'($urandom);
         clr_start  = (exp_busy || exp_done) ? 1'($urandom_range(0, 1)) : 1'b0;
         clr_colour = 3'($urandom);
         @(negedge clk);
         disp = strobe && active;
         total++;
         if (busy !== exp_busy || done !== exp_done) begin
            bad++; $display("FAIL clr_status cyc=%0d busy=%b done=%b want %b %b", c, busy, done, exp_busy, exp_done);
         end
         total++;
         if (wr_ready !== (!exp_busy && !disp)) begin
            bad++; $display("FAIL clr_ready cyc=%0d got=%b want=%b", c, wr_ready, !exp_busy && !disp);
         end
         total++;
         if (disp) begin
            a = pix_addr(int'(x), int'(y));
            if (mem_we !== 1'b0 || mem_addr !== AW'(a)) begin
               bad++; $display("FAIL clr_disp cyc=%0d we=%b addr=%0d want 0 %0d", c, mem_we, mem_addr, a);
            end
         end else if (exp_busy) begin
            if (mem_we !== 1'b1 || mem_addr !== AW'(written) || mem_wdata !== col) begin
               bad++; $display("FAIL clr_write cyc=%0d we=%b addr=%0d wdata=%b want 1 %0d %b", c, mem_we, mem_addr, mem_wdata, written, col);
            end
            ref_fb[written] = col;
            written++;
         end else begin
            if (mem_we !== 1'b0) begin
               bad++; $display("FAIL clr_idle cyc=%0d we=%b want=0", c, mem_we);
            end
         end
         if (exp_done) finished = 1'b1;
         exp_done = 1'b0;
         if (exp_busy && written == DEPTH) begin
            exp_busy = 1'b0;
            exp_done = 1'b1;
         end
         c++;
         tick();
      end
      total++;
      if (!finished) begin
         bad++; $display("FAIL clr_timeout writes=%0d want=%0d", written, DEPTH);
      end
      strobe = 1'b0; clr_start = 1'b0; wr_valid = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL clr_after busy=%b done=%b want 0 0", busy, done);
      end
      tick();
   endtask

   task automatic test_clear_abort();
      logic [2:0] col;
      int  written, c;
      col = 3'b011; written = 0; c = 0;
      strobe = 1'b0; wr_valid = 1'b0; clr_start = 1'b1; clr_colour = col;
      @(negedge clk);
      tick(); clr_start = 1'b0;
      while (written < 5000 && c < 10000) begin
         strobe = (c % 2 == 0);
         active = 1'($urandom_range(0, 1));
         x      = 10'($urandom_range(0, 639));
         y      = 9'($urandom_range(0, 479));
         @(negedge clk);
         if (!(strobe && active)) begin
            total++;
            if (mem_we !== 1'b1 || mem_addr !== AW'(written) || mem_wdata !== col) begin
               bad++; $display("FAIL abort_write cyc=%0d we=%b addr=%0d wdata=%b want 1 %0d %b", c, mem_we, mem_addr, mem_wdata, written, col);
            end
            ref_fb[written] = col;
            written++;
         end
         c++;
         tick();
      end
      total++;
      if (written < 5000) begin
         bad++; $display("FAIL abort_timeout writes=%0d want=5000", written);
      end
      rst = 1'b1; strobe = 1'b0;
      @(negedge clk);
      tick(); rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         total++;
         if (busy !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0) begin
            bad++; $display("FAIL abort_idle k=%0d busy=%b done=%b we=%b want 0 0 0", k, busy, done, mem_we);
         end
         tick();
      end
      clr_start = 1'b1; clr_colour = 3'b101;
      @(negedge clk);
      tick(); clr_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++;
         if (busy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(k) || mem_wdata !== 3'b101) begin
            bad++; $display("FAIL restart k=%0d busy=%b we=%b addr=%0d wdata=%b want 1 1 %0d 101", k, busy, mem_we, mem_addr, mem_wdata, k);
         end
         ref_fb[k] = 3'b101;
         tick();
      end
      rst = 1'b1;
      @(negedge clk);
      tick(); rst = 1'b0;
   endtask

   task automatic test_start_with_writer();
      strobe = 1'b0; clr_start = 1'b1; clr_colour = 3'b110;
      wr_valid = 1'b1; wr_addr = AW'(50); wr_data = 3'b100;
      @(negedge clk);
      total++;
      if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(50) || mem_wdata !== 3'b100 || busy !== 1'b0) begin
         bad++; $display("FAIL start_wr ready=%b we=%b addr=%0d wdata=%b busy=%b want 1 1 50 100 0", wr_ready, mem_we, mem_addr, mem_wdata, busy);
      end
      ref_fb[50] = 3'b100;
      tick(); clr_start = 1'b0; wr_valid = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== '0 || mem_wdata !== 3'b110) begin
         bad++; $display("FAIL start_clr busy=%b we=%b addr=%0d wdata=%b want 1 1 0 110", busy, mem_we, mem_addr, mem_wdata);
      end
      ref_fb[0] = 3'b110;
      tick(); rst = 1'b1;
      @(negedge clk);
      tick(); rst = 1'b0;
      strobe = 1'b1; active = 1'b1; x = 10'd200; y = '0;
      @(negedge clk);
      tick(); strobe = 1'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      total++;
      if ({red, green, blue} !== ref_fb[50]) begin
         bad++; $display("FAIL start_readback got=%b want=%b", {red, green, blue}, ref_fb[50]);
      end
      tick();
   endtask

   initial begin
      pre_en = 1'b0; pre_addr = '0; pre_data = '0;
      for (int i = 0; i < WORDS; i++) ref_fb[i] = bg(i);
      test_reset();
      test_random_traffic();
      test_display_pixel();
      test_writer_stall();
      test_out_of_range();
      test_clear();
      test_clear_abort();
      test_start_with_writer();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
